// File: rtl/pipe_share_pkg.sv
// Shared types for the pipeline-sharing controller.
// FSM states, tag layout and ID width helper.
package pipe_share_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // wide enough for up to 16 requesters
    localparam int TAG_ID_W = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_share_ctrl_arb.sv
// Round-robin arbiter with internal pointer register.
// Searches upward from the pointer and wraps.
module pipe_rr_arbiter
    import pipe_share_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               sync_rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W:0]   cand;
    logic            found;

    // first active request at or after the pointer, modulo NUM_REQ
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
        grant_valid = found & enable;
        grant       = '0;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                      : grant_idx + ID_W'(1);
        end
    end

    // pointer register, moves past the last winner
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pipe_share_ctrl.sv
// Shares one fixed-latency pipeline between NUM_REQ requesters.
// Arbitrates, tags beats, routes results and sequences flushes.
module pipe_share_ctrl
    import pipe_share_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int WIDTH    = 16,
    parameter  int PIPE_LAT = 3,
    localparam int ID_W     = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     sync_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     pipe_valid_o,
    output logic [WIDTH-1:0]         pipe_data_o,
    output logic                     pipe_sync_rst,
    input  logic                     pipe_valid_i,
    input  logic [WIDTH-1:0]         pipe_data_i,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     busy,
    output logic                     seq_err
);

    localparam int CNT_W = $clog2(PIPE_LAT + 2);

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_valid;
    logic                arb_en;

    state_e              state_q, state_d;
    logic                pvalid_q, pvalid_d;
    logic [WIDTH-1:0]    pdata_q, pdata_d;
    logic [ID_W-1:0]     issue_id_q, issue_id_d;
    tag_t [PIPE_LAT-1:0] tags_q, tags_d;
    tag_t                tag_exit;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                flush_done_q, flush_done_d;
    logic                seq_err_q, seq_err_d;
    logic                prst_q, prst_d;

    assign arb_en = !sync_rst && (state_q == ST_RUN) && !flush_req;

    pipe_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .sync_rst    (sync_rst),
        .req         (req_valid),
        .enable      (arb_en),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // next state, issue, tag shift, response routing and error tracking
    always_comb begin
        state_d      = state_q;
        pvalid_d     = grant_valid;
        pdata_d      = pdata_q;
        issue_id_d   = issue_id_q;
        tags_d       = tags_q;
        tag_exit     = tags_q[PIPE_LAT-1];
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        seq_err_d    = seq_err_q;

        unique case (state_q)
            ST_RUN:   if (flush_req) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_q == '0 && !pvalid_q) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        if (grant_valid) begin
            pdata_d    = req_data[grant_idx*WIDTH +: WIDTH];
            issue_id_d = grant_idx;
        end

        tags_d[0].valid = pvalid_q;
        tags_d[0].id    = TAG_ID_W'(issue_id_q);
        for (int i = 1; i < PIPE_LAT; i++) begin
            tags_d[i] = tags_q[i-1];
        end
        if (state_q == ST_CLEAR) begin
            tags_d = '0;
        end

        inflight_d = inflight_q + CNT_W'(grant_valid) - CNT_W'(tag_exit.valid);

        // pipeline output is stale while its reset is asserted
        if (!prst_q) begin
            if (pipe_valid_i && tag_exit.valid) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = pipe_data_i;
                rsp_id_d    = ID_W'(tag_exit.id);
            end
            if (pipe_valid_i != tag_exit.valid) begin
                seq_err_d = 1'b1;
            end
        end

        flush_done_d = (state_q == ST_CLEAR);
        prst_d       = (state_d == ST_CLEAR);
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q      <= ST_RUN;
            pvalid_q     <= 1'b0;
            pdata_q      <= '0;
            issue_id_q   <= '0;
            tags_q       <= '0;
            inflight_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            flush_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
            prst_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            pvalid_q     <= pvalid_d;
            pdata_q      <= pdata_d;
            issue_id_q   <= issue_id_d;
            tags_q       <= tags_d;
            inflight_q   <= inflight_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            flush_done_q <= flush_done_d;
            seq_err_q    <= seq_err_d;
            prst_q       <= prst_d;
        end
    end

    assign req_ready     = grant;
    assign pipe_valid_o  = pvalid_q;
    assign pipe_data_o   = pdata_q;
    assign pipe_sync_rst = prst_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_id        = rsp_id_q;
    assign flush_done    = flush_done_q;
    assign seq_err       = seq_err_q;
    assign busy          = (state_q != ST_RUN) || (inflight_q != '0);

endmodule

// File: tb/tb_pipe_share_ctrl.sv
// Directed bench for pipe_share_ctrl with a +1 pipeline model.
// Inputs driven on the falling edge, outputs sampled 1ns later.
module tb_pipe_share_ctrl;

    localparam int NUM_REQ  = 4;
    localparam int WIDTH    = 16;
    localparam int PIPE_LAT = 3;
    localparam int ID_W     = 2;

    logic                     clk = 1'b0;
    logic                     sync_rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     pipe_valid_o;
    logic [WIDTH-1:0]         pipe_data_o;
    logic                     pipe_sync_rst;
    logic                     pipe_valid_i;
    logic [WIDTH-1:0]         pipe_data_i;
    logic                     rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic                     flush_req;
    logic                     flush_done;
    logic                     busy;
    logic                     seq_err;

    int checks = 0;
    int errors = 0;

    logic [2:0]       s_v;
    logic [WIDTH-1:0] s_d0, s_d1, s_d2;
    logic             inj_v;

    always #5 clk = ~clk;

    pipe_share_ctrl #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk           (clk),
        .sync_rst      (sync_rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .pipe_valid_o  (pipe_valid_o),
        .pipe_data_o   (pipe_data_o),
        .pipe_sync_rst (pipe_sync_rst),
        .pipe_valid_i  (pipe_valid_i),
        .pipe_data_i   (pipe_data_i),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_id        (rsp_id),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .busy          (busy),
        .seq_err       (seq_err)
    );

    // three-stage +1 pipeline with synchronous reset
    always @(posedge clk) begin
        if (pipe_sync_rst) begin
            s_v  <= '0;
            s_d0 <= '0;
            s_d1 <= '0;
            s_d2 <= '0;
        end else begin
            s_v  <= {s_v[1:0], pipe_valid_o};
            s_d0 <= pipe_data_o + 16'd1;
            s_d1 <= s_d0;
            s_d2 <= s_d1;
        end
    end

    assign pipe_valid_i = s_v[2] | inj_v;
    assign pipe_data_i  = s_d2;

    task automatic set_data();
        for (int i = 0; i < NUM_REQ; i++)
            req_data[i*WIDTH +: WIDTH] = 16'h0100 * 16'(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sync_rst = 1'b1; req_valid = '0; flush_req = 1'b0; inj_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sync_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        sync_rst = 1'b1; req_valid = '1; flush_req = 1'b0; inj_v = 1'b0;
        set_data();
        @(negedge clk); #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
        checks++; if (pipe_valid_o !== 1'b0) begin errors++; $display("FAIL rst_pipe_valid got %b exp 0", pipe_valid_o); end
        checks++; if (pipe_data_o !== 16'h0) begin errors++; $display("FAIL rst_pipe_data got %h exp 0", pipe_data_o); end
        checks++; if (pipe_sync_rst !== 1'b1) begin errors++; $display("FAIL rst_pipe_sync_rst got %b exp 1", pipe_sync_rst); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_rsp_id got %0d exp 0", rsp_id); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL rst_flush_done got %b exp 0", flush_done); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL rst_seq_err got %b exp 0", seq_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        @(negedge clk);
        sync_rst = 1'b0; req_valid = '0;
        #1;
        checks++; if (pipe_sync_rst !== 1'b1) begin errors++; $display("FAIL rst_release_prst got %b exp 1", pipe_sync_rst); end
        @(negedge clk); #1;
        checks++; if (pipe_sync_rst !== 1'b0) begin errors++; $display("FAIL rst_after_prst got %b exp 0", pipe_sync_rst); end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        req_data = '0; req_data[15:0] = 16'h0010; req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (c == 1) begin
                checks++; if (pipe_valid_o !== 1'b1 || pipe_data_o !== 16'h0010) begin errors++; $display("FAIL single_issue got %b/%h exp 1/0010", pipe_valid_o, pipe_data_o); end
            end
            if (c == 4) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c4 got %b exp 1", busy); end
            end
            checks++; if (rsp_valid !== (c == 5)) begin errors++; $display("FAIL single_rsp_valid c%0d got %b exp %b", c, rsp_valid, c == 5); end
            if (c == 5) begin
                checks++; if (rsp_data !== 16'h0011 || rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp got %h/%0d exp 0011/0", rsp_data, rsp_id); end
            end
            if (c == 6) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_c6 got %b exp 0", busy); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  er;
        logic [15:0] ed;
        logic [1:0]  ei;
        do_reset();
        set_data();
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                er = 4'b0001 << (c % 4);
                checks++; if (req_ready !== er) begin errors++; $display("FAIL b2b_ready c%0d got %b exp %b", c, req_ready, er); end
            end
            if (c >= 5 && c < 13) begin
                ei = 2'((c - 5) % 4);
                ed = 16'h0100 * 16'(ei) + 16'h0001;
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== ei || rsp_data !== ed) begin errors++; $display("FAIL b2b_rsp c%0d got %b/%0d/%h exp 1/%0d/%h", c, rsp_valid, rsp_id, rsp_data, ei, ed); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle c%0d got %b exp 0", c, rsp_valid); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] rv [3];
        logic [3:0] er [3];
        logic [1:0] ei [3];
        rv = '{4'b1000, 4'b1001, 4'b1001};
        er = '{4'b1000, 4'b0001, 4'b1000};
        ei = '{2'd3, 2'd0, 2'd3};
        do_reset();
        set_data();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            req_valid = (c < 3) ? rv[c] : 4'b0000;
            #1;
            if (c < 3) begin
                checks++; if (req_ready !== er[c]) begin errors++; $display("FAIL wrap_ready c%0d got %b exp %b", c, req_ready, er[c]); end
            end
            if (c >= 5 && c <= 7) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== ei[c-5]) begin errors++; $display("FAIL wrap_rsp c%0d got %b/%0d exp 1/%0d", c, rsp_valid, rsp_id, ei[c-5]); end
            end
        end
    endtask

    task automatic test_flush();
        logic [3:0] er;
        logic [1:0] ei;
        logic       erv;
        do_reset();
        set_data();
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            req_valid = (c <= 10) ? 4'b1111 : 4'b0000;
            flush_req = (c == 3);
            #1;
            if (c < 3)       er = 4'b0001 << c;
            else if (c == 9) er = 4'b1000;
            else if (c == 10) er = 4'b0001;
            else             er = 4'b0000;
            checks++; if (req_ready !== er) begin errors++; $display("FAIL flush_ready c%0d got %b exp %b", c, req_ready, er); end
            if (c >= 3) begin
                checks++; if (pipe_sync_rst !== (c == 8)) begin errors++; $display("FAIL flush_prst c%0d got %b exp %b", c, pipe_sync_rst, c == 8); end
                checks++; if (flush_done !== (c == 9)) begin errors++; $display("FAIL flush_done c%0d got %b exp %b", c, flush_done, c == 9); end
            end
            if (c == 8) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy got %b exp 1", busy); end
            end
            erv = (c >= 5 && c <= 7) || c == 14 || c == 15;
            checks++; if (rsp_valid !== erv) begin errors++; $display("FAIL flush_rsp_valid c%0d got %b exp %b", c, rsp_valid, erv); end
            if (erv) begin
                ei = (c == 14) ? 2'd3 : (c == 15) ? 2'd0 : 2'(c - 5);
                checks++; if (rsp_id !== ei) begin errors++; $display("FAIL flush_rsp_id c%0d got %0d exp %0d", c, rsp_id, ei); end
            end
        end
    endtask

    task automatic test_sync_rst();
        do_reset();
        set_data();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            req_valid = (c < 3) ? 4'b1111 : 4'b0000;
            sync_rst  = (c == 3);
            #1;
            if (c == 3) begin
                checks++; if (pipe_valid_o !== 1'b1 || pipe_data_o !== 16'h0200) begin errors++; $display("FAIL srst_pre got %b/%h exp 1/0200", pipe_valid_o, pipe_data_o); end
            end
            if (c == 4) begin
                checks++; if (pipe_valid_o !== 1'b0 || pipe_data_o !== 16'h0) begin errors++; $display("FAIL srst_pipe got %b/%h exp 0/0000", pipe_valid_o, pipe_data_o); end
                checks++; if (pipe_sync_rst !== 1'b1) begin errors++; $display("FAIL srst_prst got %b exp 1", pipe_sync_rst); end
                checks++; if (busy !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL srst_busy_fd got %b/%b exp 0/0", busy, flush_done); end
                checks++; if (rsp_data !== 16'h0 || rsp_id !== 2'd0) begin errors++; $display("FAIL srst_rsp got %h/%0d exp 0/0", rsp_data, rsp_id); end
            end
            if (c >= 4) begin
                checks++; if (rsp_valid !== 1'b0 || seq_err !== 1'b0) begin errors++; $display("FAIL srst_drop c%0d got %b/%b exp 0/0", c, rsp_valid, seq_err); end
            end
        end
    endtask

    task automatic test_seq_err();
        do_reset();
        @(negedge clk);
        inj_v = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            inj_v = 1'b0;
            #1;
            checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seqerr_set c%0d got %b exp 1", c, seq_err); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL seqerr_rsp c%0d got %b exp 0", c, rsp_valid); end
        end
        do_reset();
        #1;
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seqerr_clear got %b exp 0", seq_err); end
    endtask

    initial begin
        sync_rst  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        flush_req = 1'b0;
        inj_v     = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_sync_rst();
        test_seq_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
